// File: rtl/datapath_test_sequencer.sv
// datapath_test_sequencer
// Programmable micro-op sequencer for the regfile/ALU datapath. Micro-ops are
// loaded into a small memory and then issued, either back-to-back (run mode)
// or one per step pulse (step mode). CHECK ops compare the ALU result bus
// against an expected value and keep a saturating mismatch count plus the pc
// of the first mismatch.
module datapath_test_sequencer #(
    parameter int DATA_W = 16,
    parameter int NREG = 16,
    parameter int RA_W = 4,
    parameter int DEPTH = 32,
    parameter int PC_W = 5,
    parameter logic [3:0] NOP_OPCODE = 4'h0,
    parameter int INSTR_W = 2 + 3*RA_W + 2 + 4 + 1 + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [PC_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [NREG-1:0]    reg_en,
    output logic [RA_W-1:0]    reg_a,
    output logic [RA_W-1:0]    reg_b,
    output logic [DATA_W-1:0]  imm,
    output logic [1:0]         b_sel,
    output logic [3:0]         opcode,
    output logic               flag_en,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         fail_count,
    output logic [PC_W-1:0]    fail_pc
);

    localparam int FLAG_BIT = DATA_W;
    localparam int OPC_LSB  = DATA_W + 1;
    localparam int BSEL_LSB = DATA_W + 5;
    localparam int RB_LSB   = DATA_W + 7;
    localparam int RA_LSB   = RB_LSB + RA_W;
    localparam int DST_LSB  = RA_LSB + RA_W;
    localparam int KIND_LSB = DST_LSB + RA_W;
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PC_W-1:0]    pc;
    logic               fail_seen;

    logic [INSTR_W-1:0] instr;
    logic [1:0]         op_kind;
    logic [RA_W-1:0]    op_dst;
    logic [RA_W-1:0]    op_ra;
    logic [RA_W-1:0]    op_rb;
    logic [1:0]         op_bsel;
    logic [3:0]         op_opc;
    logic               op_flag;
    logic [DATA_W-1:0]  op_imm;
    logic [NREG-1:0]    dst_onehot;

    logic issue;
    logic is_exec;
    logic is_check;
    logic is_halt;
    logic check_fail;
    logic can_start;

    assign instr   = mem[pc];
    assign op_kind = instr[KIND_LSB +: 2];
    assign op_dst  = instr[DST_LSB +: RA_W];
    assign op_ra   = instr[RA_LSB +: RA_W];
    assign op_rb   = instr[RB_LSB +: RA_W];
    assign op_bsel = instr[BSEL_LSB +: 2];
    assign op_opc  = instr[OPC_LSB +: 4];
    assign op_flag = instr[FLAG_BIT];
    assign op_imm  = instr[DATA_W-1:0];

    assign is_exec  = (op_kind == 2'b00);
    assign is_check = (op_kind == 2'b01);
    assign is_halt  = op_kind[1];

    assign can_start = (state == S_IDLE) || (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_STEP_WAIT);
    assign done      = (state == S_DONE);
    assign pass      = done && (fail_count == 8'd0);

    // Micro-op memory; writes are only accepted while the sequencer is not busy.
    always_ff @(posedge clk) begin
        if (load_en && can_start && (int'(load_addr) < DEPTH)) begin
            mem[load_addr] <= load_data;
        end
    end

    // Issue decode, control bus generation and next-state selection.
    always_comb begin
        issue      = !rst && ((state == S_RUN) || ((state == S_STEP_WAIT) && step));
        dst_onehot = (int'(op_dst) < NREG) ? ({{(NREG-1){1'b0}}, 1'b1} << op_dst) : '0;
        reg_en     = '0;
        reg_a      = '0;
        reg_b      = '0;
        imm        = '0;
        b_sel      = 2'b00;
        opcode     = NOP_OPCODE;
        flag_en    = 1'b0;
        check_fail = 1'b0;
        state_next = state;

        // A CHECK's imm field is the expected value, not an operand, so the imm bus stays 0.
        if (issue && !is_halt) begin
            reg_a  = op_ra;
            reg_b  = op_rb;
            b_sel  = op_bsel;
            opcode = op_opc;
            if (is_exec) begin
                reg_en  = dst_onehot;
                imm     = op_imm;
                flag_en = op_flag;
            end
            if (is_check && (alu_result != op_imm)) begin
                check_fail = 1'b1;
            end
        end

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = step_mode ? S_STEP_WAIT : S_RUN;
                end
            end
            S_RUN, S_STEP_WAIT: begin
                if (issue && (is_halt || (pc == LAST_PC))) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, program counter and CHECK bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            fail_count <= 8'd0;
            fail_pc    <= '0;
            fail_seen  <= 1'b0;
        end else begin
            state <= state_next;
            if (can_start && start) begin
                pc         <= '0;
                fail_count <= 8'd0;
                fail_pc    <= '0;
                fail_seen  <= 1'b0;
            end else begin
                if (issue && !is_halt && (pc != LAST_PC)) begin
                    pc <= pc + 1'b1;
                end
                if (check_fail) begin
                    if (fail_count != 8'hFF) begin
                        fail_count <= fail_count + 8'd1;
                    end
                    if (!fail_seen) begin
                        fail_seen <= 1'b1;
                        fail_pc   <= pc;
                    end
                end
            end
        end
    end

endmodule
